// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//
// Purpose:
//   Holds a small 16 x 16 program memory loaded by a host and steps through it,
//   presenting one instruction at a time to a processor. The processor
//   acknowledges each instruction with cpu_done. Opcode 3'b001 (mvi) is a
//   two-word instruction: the instruction word is followed by its immediate.
//   A watchdog aborts to ERR if the processor stalls in WAIT.
//
// Ports:
//   clk          in   1   clock, rising edge
//   resetn       in   1   asynchronous active-low reset
//   prog_we      in   1   host write strobe (honoured only in IDLE / ERR)
//   prog_addr    in   4   host write address
//   prog_wdata   in  16   host write data
//   prog_len     in   5   program length in words, latched at start, clamped to 16
//   start        in   1   begin execution (honoured only in IDLE / ERR)
//   cpu_done     in   1   processor finished the current instruction
//   din          out 16   instruction word in ISSUE, immediate (mvi) or word in WAIT
//   run          out  1   instruction valid (ISSUE, WAIT)
//   busy         out  1   high in every state except IDLE
//   finished     out  1   one-cycle pulse on normal completion
//   err          out  1   sticky error flag
//   pc           out  4   address of the current instruction
//   instr_count  out  5   instructions retired since the last start
// -----------------------------------------------------------------------------
module prog_sequencer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [15:0] prog_wdata,
    input  logic [4:0]  prog_len,
    input  logic        start,
    input  logic        cpu_done,
    output logic [15:0] din,
    output logic        run,
    output logic        busy,
    output logic        finished,
    output logic        err,
    output logic [3:0]  pc,
    output logic [4:0]  instr_count
);

    localparam logic [2:0] OP_MVI  = 3'b001;
    // Watchdog value seen in the 15th WAIT cycle; expiry fires at that edge.
    localparam logic [3:0] WD_LAST = 4'd14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_FINISH,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_mem [0:15];
    logic [15:0] r_din;
    // pc is one bit wider than the address so that it can reach 16 at the end.
    logic [4:0]  r_pc;
    logic [4:0]  r_len;
    logic [4:0]  r_count;
    logic [3:0]  r_wd;
    logic        r_err;
    logic        r_is_mvi;

    logic [4:0]  w_len_clamped;
    logic [15:0] w_fetch_word;
    logic [15:0] w_imm_word;
    logic        w_fetch_mvi;
    logic [4:0]  w_pc_adv;
    logic        w_start_go;
    logic        w_fetch_err;
    logic        w_retire;
    logic        w_wd_fire;

    assign w_len_clamped = (prog_len > 5'd16) ? 5'd16 : prog_len;
    assign w_fetch_word  = r_mem[r_pc[3:0]];
    // Only read while an mvi is in flight, which guarantees pc+1 < len <= 16.
    assign w_imm_word    = r_mem[r_pc[3:0] + 4'd1];
    assign w_fetch_mvi   = (w_fetch_word[8:6] == OP_MVI);
    assign w_pc_adv      = r_pc + (r_is_mvi ? 5'd2 : 5'd1);

    assign din         = r_din;
    assign err         = r_err;
    assign pc          = r_pc[3:0];
    assign instr_count = r_count;

    // Program memory: no reset so contents survive resetn.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state == S_IDLE || r_state == S_ERR)) begin
            r_mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_go   = 1'b0;
        w_fetch_err  = 1'b0;
        w_retire     = 1'b0;
        w_wd_fire    = 1'b0;
        run          = 1'b0;
        busy         = (r_state != S_IDLE);
        finished     = 1'b0;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    w_start_go   = 1'b1;
                    w_state_next = (w_len_clamped == 5'd0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                // An mvi whose immediate lies beyond the program is malformed.
                if (w_fetch_mvi && ((r_pc + 5'd1) >= r_len)) begin
                    w_fetch_err  = 1'b1;
                    w_state_next = S_ERR;
                end else begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                run          = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                run = 1'b1;
                // cpu_done wins over a simultaneous watchdog expiry.
                if (cpu_done) begin
                    w_retire     = 1'b1;
                    w_state_next = (w_pc_adv >= r_len) ? S_FINISH : S_FETCH;
                end else if (r_wd == WD_LAST) begin
                    w_wd_fire    = 1'b1;
                    w_state_next = S_ERR;
                end
            end
            S_FINISH: begin
                finished     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_din    <= '0;
            r_pc     <= '0;
            r_len    <= '0;
            r_count  <= '0;
            r_wd     <= '0;
            r_err    <= 1'b0;
            r_is_mvi <= 1'b0;
        end else begin
            if (w_start_go) begin
                r_pc    <= '0;
                r_count <= '0;
                r_err   <= 1'b0;
                r_len   <= w_len_clamped;
            end
            if (r_state == S_FETCH) begin
                r_din    <= w_fetch_word;
                r_is_mvi <= w_fetch_mvi;
                r_wd     <= '0;
            end
            // Swap in the immediate so WAIT presents it to the processor.
            if (r_state == S_ISSUE && r_is_mvi) begin
                r_din <= w_imm_word;
            end
            if (r_state == S_WAIT) begin
                r_wd <= r_wd + 4'd1;
            end
            if (w_retire) begin
                r_pc    <= w_pc_adv;
                r_count <= r_count + 5'd1;
            end
            if (w_fetch_err || w_wd_fire) begin
                r_err <= 1'b1;
            end
            // Park din at zero whenever execution stops, so IDLE shows 0.
            if (w_state_next == S_FINISH || w_state_next == S_ERR) begin
                r_din <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// -----------------------------------------------------------------------------
// tb_prog_sequencer
//
// Purpose:
//   Self-checking bench for prog_sequencer. A program-level reference model
//   walks the program image (word by word, mvi taking two words) and predicts
//   the issued/waited words, retirements, final pc and error outcome; a
//   processor responder acknowledges each instruction after a chosen delay.
//   Directed programs come first, then randomized programs.
// -----------------------------------------------------------------------------
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [15:0] prog_wdata = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        cpu_done = 1'b0;
    logic [15:0] din;
    logic        run;
    logic        busy;
    logic        finished;
    logic        err;
    logic [3:0]  pc;
    logic [4:0]  instr_count;

    always #5 clk = ~clk;

    prog_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .prog_len    (prog_len),
        .start       (start),
        .cpu_done    (cpu_done),
        .din         (din),
        .run         (run),
        .busy        (busy),
        .finished    (finished),
        .err         (err),
        .pc          (pc),
        .instr_count (instr_count)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_mem [16];
    int          k_del [16];   // WAIT cycle in which cpu_done is raised, per issued instruction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < 16; i++) begin
            prog_we    = 1'b1;
            prog_addr  = i[3:0];
            prog_wdata = m_mem[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    function automatic logic [15:0] rand_word(input bit allow_mvi);
        logic [15:0] w;
        w = 16'($urandom_range(0, 65535));
        if (allow_mvi && $urandom_range(0, 3) == 0) w[8:6] = 3'b001;
        else w[8:6] = 3'($urandom_range(2, 7));
        return w;
    endfunction

    // Start the program at the current edge, respond as the processor, and
    // compare the whole execution against the program-level model.
    task automatic exec_prog(input int len_in, input string name);
        int          eff_len, mpc, mcnt, n_exp, n_rises, wcnt, first_run, idx;
        bit          exp_err, exp_wd, ended, prev_run, is_mvi;
        logic [15:0] exp_issue [16];
        logic [15:0] exp_wait  [16];
        logic [15:0] w;

        eff_len = (len_in > 16) ? 16 : len_in;
        mpc = 0; mcnt = 0; n_exp = 0; exp_err = 0; exp_wd = 0;
        while (mpc < eff_len) begin
            w      = m_mem[mpc];
            is_mvi = (w[8:6] == 3'b001);
            if (is_mvi && (mpc + 1 >= eff_len)) begin
                exp_err = 1;
                break;
            end
            exp_issue[n_exp] = w;
            exp_wait[n_exp]  = is_mvi ? m_mem[mpc + 1] : w;
            n_exp++;
            if (k_del[n_exp - 1] > 15) begin
                exp_err = 1;
                exp_wd  = 1;
                break;
            end
            mpc += is_mvi ? 2 : 1;
            mcnt++;
        end

        start    = 1'b1;
        prog_len = len_in[4:0];
        cpu_done = 1'b0;
        tick();
        start = 1'b0;
        check_eq({name, "/err_clr"}, err, 0);
        check_eq({name, "/busy"}, busy, 1);

        n_rises = 0; wcnt = 0; first_run = -1; prev_run = 0; ended = 0;
        for (int cyc = 1; cyc < 600 && !ended; cyc++) begin
            start    = 1'b0;
            cpu_done = 1'b0;
            idx      = (n_rises > 0 && n_rises <= 16) ? n_rises - 1 : 0;
            if (run && !prev_run) begin
                if (n_rises == 0) first_run = cyc;
                if (n_rises < n_exp) check_eq({name, "/issue_din"}, din, exp_issue[n_rises]);
                n_rises++;
                wcnt = 0;
                cpu_done = 1'($urandom_range(0, 1));   // must be ignored in ISSUE
            end else if (run) begin
                wcnt++;
                if (wcnt == 1 && n_rises <= n_exp) check_eq({name, "/wait_din"}, din, exp_wait[idx]);
                cpu_done = (wcnt == k_del[idx]);
            end else begin
                if (prev_run && exp_wd && err) check_eq({name, "/wd_cycles"}, wcnt, 15);
                cpu_done = 1'($urandom_range(0, 1));   // must be ignored outside WAIT
            end
            if (finished || err) begin
                ended    = 1;
                cpu_done = 1'b0;
            end else begin
                start = ($urandom_range(0, 3) == 0);   // must be ignored while executing
            end
            prev_run = run;
            if (!ended) tick();
        end
        start    = 1'b0;
        cpu_done = 1'b0;

        if (!ended) check_eq({name, "/timeout"}, 0, 1);
        check_eq({name, "/issues"}, n_rises, n_exp);
        check_eq({name, "/err"}, err, exp_err);
        check_eq({name, "/instr_count"}, instr_count, mcnt);
        check_eq({name, "/pc"}, pc, mpc[3:0]);
        check_eq({name, "/finished"}, finished, !exp_err);
        if (n_exp > 0) check_eq({name, "/latency"}, first_run, 2);
        tick();
        check_eq({name, "/fin_pulse"}, finished, 0);
        check_eq({name, "/busy_after"}, busy, exp_err);
        if (!exp_err) check_eq({name, "/idle_din"}, din, 0);
        $display("prog %s len=%0d issued=%0d retired=%0d pc=%0d err=%0b", name, len_in, n_rises, mcnt, mpc, exp_err);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0;
            k_del[i] = 1;
        end

        // Reset state, before any clock edge
        #2;
        check_eq("rst/din", din, 0);
        check_eq("rst/run", run, 0);
        check_eq("rst/busy", busy, 0);
        check_eq("rst/finished", finished, 0);
        check_eq("rst/err", err, 0);
        check_eq("rst/pc", pc, 0);
        check_eq("rst/instr_count", instr_count, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Single mv R1,R0, acknowledged in the 3rd WAIT cycle
        m_mem[0] = 16'h0008;
        load_mem();
        k_del[0] = 3;
        exec_prog(1, "mv1");

        // mvi R1 with immediate 0x1234
        m_mem[0] = 16'h0048;
        m_mem[1] = 16'h1234;
        load_mem();
        k_del[0] = 2;
        exec_prog(2, "mvi");

        // 16 single-word instructions: pc must reach 16 without wrapping
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = rand_word(0);
            k_del[i] = $urandom_range(1, 3);
        end
        load_mem();
        exec_prog(16, "full16");
        exec_prog(27, "clamp27");

        // Watchdog expiry, then a restart from ERR with cpu_done on the last legal cycle
        m_mem[0] = 16'h0008;
        load_mem();
        k_del[0] = 16;
        exec_prog(1, "watchdog");
        k_del[0] = 15;
        exec_prog(1, "wd_edge");

        // mvi at the last address of the program, and an empty program
        m_mem[0] = 16'h0008;
        m_mem[1] = 16'h0010;
        m_mem[2] = 16'h0019;
        m_mem[3] = 16'h0048;
        load_mem();
        for (int i = 0; i < 16; i++) k_del[i] = 1;
        exec_prog(4, "mvi_trunc");
        exec_prog(0, "len0");

        // Reset in WAIT, with a host write attempted while busy
        m_mem[0] = 16'h0008;
        load_mem();
        start    = 1'b1;
        prog_len = 5'd1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && !run; i++) tick();
        check_eq("rstw/run_seen", run, 1);
        tick();
        prog_we    = 1'b1;
        prog_addr  = 4'd0;
        prog_wdata = 16'hFFFF;
        tick();
        prog_we = 1'b0;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check_eq("rstw/din", din, 0);
        check_eq("rstw/run", run, 0);
        check_eq("rstw/busy", busy, 0);
        check_eq("rstw/finished", finished, 0);
        check_eq("rstw/err", err, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check_eq("rstw/no_fin", finished, 0);
        check_eq("rstw/idle", busy, 0);
        k_del[0] = 2;
        exec_prog(1, "after_rst");

        // Randomized programs
        for (int t = 0; t < 25; t++) begin
            int r;
            for (int i = 0; i < 16; i++) begin
                m_mem[i] = rand_word(1);
                r = $urandom_range(0, 24);
                k_del[i] = (r == 0) ? 16 : (r == 1) ? 15 : $urandom_range(1, 4);
            end
            load_mem();
            exec_prog($urandom_range(0, 31), $sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
